// File: rtl/hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : hack_rom_loader
// Description : Program ROM in front of hack_cpu. Fills the ROM from a
//               valid/ready byte stream, verifies an XOR checksum, then
//               releases the CPU and serves instructions combinationally.
//
//   Stream: LEN_HI LEN_LO {HI LO} x N CHK, where CHK is the XOR of every
//           preceding byte (header included).
//
//   Ports
//     clock         system clock, rising edge
//     reset         synchronous active-high, back to the load-wait state
//     in_valid      byte source has in_data
//     in_ready      block accepts in_data this cycle
//     in_data[7:0]  stream byte
//     reload        one-cycle request to restart loading (RUN/ERROR only)
//     pc[14:0]      CPU program counter (bits >= ADDR_W ignored)
//     instr[15:0]   instruction at pc while running, else zero
//     cpu_reset     registered CPU reset, low only while running
//     loading       high in any load state
//     error         sticky load-failure flag
//     words_loaded  words written during the current load
//
// Revision    : 1.0 - initial release
// ============================================================================
module hack_rom_loader #(
   parameter int ADDR_W = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        reload,
   input  logic [14:0] pc,
   output logic [15:0] instr,
   output logic        cpu_reset,
   output logic        loading,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam int          c_DEPTH   = 1 << ADDR_W;
   localparam logic [16:0] c_DEPTH_W = 17'(c_DEPTH);

   typedef enum logic [2:0] {
      S_LEN_HI  = 3'd0,
      S_LEN_LO  = 3'd1,
      S_DATA_HI = 3'd2,
      S_DATA_LO = 3'd3,
      S_CHECK   = 3'd4,
      S_RUN     = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

   state_t              r_state;
   logic [15:0]         r_len;
   logic [7:0]          r_hi;
   logic [7:0]          r_xor;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_words;
   logic                r_cpu_reset;
   logic                r_error;
   logic [15:0]         r_rom [c_DEPTH];

   logic                w_load_state;
   logic                w_accept;
   logic [15:0]         w_len;
   logic                w_rom_we;

   // Ready and loading are pure decodes of the state register, so a reload
   // cycle in RUN/ERROR can never consume a byte.
   assign w_load_state = (r_state != S_RUN) && (r_state != S_ERROR);
   assign in_ready     = w_load_state;
   assign loading      = w_load_state;
   assign w_accept     = in_valid && w_load_state;

   // Full length as it will be after the LO byte is taken.
   assign w_len        = {r_len[15:8], in_data};
   assign w_rom_we     = w_accept && (r_state == S_DATA_LO);

   assign cpu_reset    = r_cpu_reset;
   assign error        = r_error;
   assign words_loaded = r_words;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_LEN_HI;
         r_len       <= 16'h0000;
         r_hi        <= 8'h00;
         r_xor       <= 8'h00;
         r_addr      <= '0;
         r_words     <= 16'h0000;
         r_cpu_reset <= 1'b1;
         r_error     <= 1'b0;
      end else begin
         case (r_state)
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len[15:8] <= in_data;
                  r_xor       <= r_xor ^ in_data;
                  r_state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  r_len <= w_len;
                  r_xor <= r_xor ^ in_data;
                  if (w_len == 16'h0000) begin
                     r_state <= S_CHECK;
                  end else if ({1'b0, w_len} > c_DEPTH_W) begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (w_accept) begin
                  r_hi    <= in_data;
                  r_xor   <= r_xor ^ in_data;
                  r_state <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (w_accept) begin
                  r_xor   <= r_xor ^ in_data;
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_words <= r_words + 16'd1;
                  if ((r_words + 16'd1) == r_len) begin
                     r_state <= S_CHECK;
                  end else begin
                     r_state <= S_DATA_HI;
                  end
               end
            end
            S_CHECK: begin
               if (w_accept) begin
                  if (in_data == r_xor) begin
                     r_state     <= S_RUN;
                     r_cpu_reset <= 1'b0;
                  end else begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
            S_RUN, S_ERROR: begin
               // Restart: accumulators cleared on the way into LEN_HI.
               if (reload) begin
                  r_state     <= S_LEN_HI;
                  r_cpu_reset <= 1'b1;
                  r_error     <= 1'b0;
                  r_words     <= 16'h0000;
                  r_xor       <= 8'h00;
                  r_addr      <= '0;
               end
            end
            default: begin
               r_state     <= S_LEN_HI;
               r_cpu_reset <= 1'b1;
            end
         endcase
      end
   end

   // ROM storage is deliberately outside the reset domain: contents survive
   // reset and reload, and words past N keep whatever they held before.
   always_ff @(posedge clock) begin
      if (w_rom_we) begin
         r_rom[r_addr] <= {r_hi, in_data};
      end
   end

   // Zero-latency read so the CPU sees its instruction in the same cycle.
   always_comb begin
      instr = 16'h0000;
      if (r_state == S_RUN) begin
         instr = r_rom[pc[ADDR_W-1:0]];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_rom_loader
// Description : Self-checking bench for hack_rom_loader. Two instances share
//               the stimulus: dut_a uses the full 15-bit ROM, dut_b uses a
//               16-word ROM for the length-limit and address-wrap cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_rom_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        reload;
   logic [14:0] pc;

   logic        a_in_ready, a_cpu_reset, a_loading, a_error;
   logic [15:0] a_instr, a_words;
   logic        b_in_ready, b_cpu_reset, b_loading, b_error;
   logic [15:0] b_instr, b_words;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference ROM contents: address -> word, written from the image rules.
   logic [15:0] m_rom_a [int];
   logic [15:0] m_rom_b [int];

   always #5 clock = ~clock;

   hack_rom_loader #(.ADDR_W(15)) dut_a (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .reload(reload), .pc(pc), .instr(a_instr),
      .cpu_reset(a_cpu_reset), .loading(a_loading), .error(a_error),
      .words_loaded(a_words)
   );

   hack_rom_loader #(.ADDR_W(4)) dut_b (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .reload(reload), .pc(pc), .instr(b_instr),
      .cpu_reset(b_cpu_reset), .loading(b_loading), .error(b_error),
      .words_loaded(b_words)
   );

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [7:0] b, input int gap);
      in_valid = 1'b0;
      repeat (gap) @(posedge clock);
      if (gap > 0) #1;
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_reload;
      reload = 1'b1;
      @(posedge clock);
      #1;
      reload = 1'b0;
   endtask

   task automatic pulse_reset;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Builds the byte stream for an image, sends it, and records the words
   // the image places in ROM (they land whether or not CHK matches).
   task automatic load_image(input int d, input logic [15:0] w[$],
                             input logic [7:0] flip, input int maxgap);
      logic [7:0] q[$];
      logic [7:0] x;
      int n;
      n = w.size();
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      foreach (w[i]) begin
         q.push_back(w[i][15:8]);
         q.push_back(w[i][7:0]);
      end
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      q.push_back(x ^ flip);
      foreach (q[i]) send(q[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
      foreach (w[i]) begin
         if (d == 0) m_rom_a[i] = w[i];
         else        m_rom_b[i % 16] = w[i];
      end
   endtask

   task automatic test_reset;
      in_valid = 1'b0; in_data = 8'h00; reload = 1'b0; pc = 15'd0; reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
      n_cmp++; if (a_loading !== 1'b1) begin n_bad++; $display("FAIL reset_loading: got %b want 1", a_loading); end
      n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_reset: got %b want 1", a_cpu_reset); end
      n_cmp++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", a_error); end
      n_cmp++; if (a_words !== 16'd0) begin n_bad++; $display("FAIL reset_words: got %h want 0000", a_words); end
      n_cmp++; if (a_instr !== 16'h0000) begin n_bad++; $display("FAIL reset_instr: got %h want 0000", a_instr); end
      n_cmp++; if (b_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reset_b_cpu_reset: got %b want 1", b_cpu_reset); end
   endtask

   task automatic test_basic_load;
      logic [7:0] s[$];
      logic [7:0] x;
      s = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
      x = 8'h00;
      foreach (s[i]) begin send(s[i], 0); x ^= s[i]; end
      n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL basic_cpu_reset_pre_chk: got %b want 1", a_cpu_reset); end
      n_cmp++; if (a_words !== 16'd2) begin n_bad++; $display("FAIL basic_words_pre_chk: got %0d want 2", a_words); end
      send(x, 0);
      m_rom_a[0] = 16'hABCD; m_rom_a[1] = 16'h1234;
      n_cmp++; if (a_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL basic_cpu_reset: got %b want 0", a_cpu_reset); end
      n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready: got %b want 0", a_in_ready); end
      n_cmp++; if (a_loading !== 1'b0) begin n_bad++; $display("FAIL basic_loading: got %b want 0", a_loading); end
      n_cmp++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b want 0", a_error); end
      pc = 15'd1; #1;
      n_cmp++; if (a_instr !== 16'h1234) begin n_bad++; $display("FAIL basic_instr1: got %h want 1234", a_instr); end
      pc = 15'd0; #1;
      n_cmp++; if (a_instr !== 16'hABCD) begin n_bad++; $display("FAIL basic_instr0: got %h want abcd", a_instr); end
   endtask

   task automatic test_gaps;
      logic [15:0] w[$];
      w = '{16'hABCD, 16'h1234};
      pulse_reload;
      load_image(0, w, 8'h00, 5);
      n_cmp++; if (a_words !== 16'd2) begin n_bad++; $display("FAIL gaps_words: got %0d want 2", a_words); end
      n_cmp++; if (a_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL gaps_cpu_reset: got %b want 0", a_cpu_reset); end
      n_cmp++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL gaps_error: got %b want 0", a_error); end
      for (int p = 0; p < 2; p++) begin
         pc = 15'(p); #1;
         n_cmp++; if (a_instr !== w[p]) begin n_bad++; $display("FAIL gaps_instr[%0d]: got %h want %h", p, a_instr, w[p]); end
      end
   endtask

   task automatic test_bad_chk;
      logic [15:0] w[$];
      w = '{16'hABCD, 16'h1234};
      pulse_reload;
      load_image(0, w, 8'h01, 0);
      pc = 15'd1; #1;
      n_cmp++; if (a_error !== 1'b1) begin n_bad++; $display("FAIL badchk_error: got %b want 1", a_error); end
      n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL badchk_cpu_reset: got %b want 1", a_cpu_reset); end
      n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL badchk_in_ready: got %b want 0", a_in_ready); end
      n_cmp++; if (a_loading !== 1'b0) begin n_bad++; $display("FAIL badchk_loading: got %b want 0", a_loading); end
      n_cmp++; if (a_instr !== 16'h0000) begin n_bad++; $display("FAIL badchk_instr: got %h want 0000", a_instr); end
      // error is sticky across idle cycles
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (a_error !== 1'b1) begin n_bad++; $display("FAIL badchk_sticky: got %b want 1", a_error); end
   endtask

   task automatic test_reload_recover;
      logic [15:0] w[$];
      w = '{16'($urandom)};
      pulse_reload;
      n_cmp++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL recover_error_clr: got %b want 0", a_error); end
      n_cmp++; if (a_loading !== 1'b1) begin n_bad++; $display("FAIL recover_loading: got %b want 1", a_loading); end
      load_image(0, w, 8'h00, 2);
      pc = 15'd0; #1;
      n_cmp++; if (a_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL recover_cpu_reset: got %b want 0", a_cpu_reset); end
      n_cmp++; if (a_words !== 16'd1) begin n_bad++; $display("FAIL recover_words: got %0d want 1", a_words); end
      n_cmp++; if (a_instr !== w[0]) begin n_bad++; $display("FAIL recover_instr: got %h want %h", a_instr, w[0]); end
   endtask

   task automatic test_zero_len;
      logic [15:0] w[$];
      pulse_reload;
      load_image(0, w, 8'h00, 1);
      n_cmp++; if (a_words !== 16'd0) begin n_bad++; $display("FAIL zero_words: got %0d want 0", a_words); end
      n_cmp++; if (a_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL zero_cpu_reset: got %b want 0", a_cpu_reset); end
      n_cmp++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL zero_error: got %b want 0", a_error); end
      foreach (m_rom_a[k]) begin
         pc = 15'(k); #1;
         n_cmp++; if (a_instr !== m_rom_a[k]) begin n_bad++; $display("FAIL zero_instr[%0d]: got %h want %h", k, a_instr, m_rom_a[k]); end
      end
   endtask

   task automatic test_random_images;
      for (int it = 0; it < 6; it++) begin
         logic [15:0] w[$];
         logic [7:0]  flip;
         logic        exp_err;
         int          n;
         n = int'($urandom_range(8, 1));
         for (int i = 0; i < n; i++) w.push_back(16'($urandom));
         flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         exp_err = (flip != 8'h00);
         pulse_reload;
         load_image(0, w, flip, 3);
         n_cmp++; if (a_words !== 16'(n)) begin n_bad++; $display("FAIL rand%0d_words: got %0d want %0d", it, a_words, n); end
         n_cmp++; if (a_error !== exp_err) begin n_bad++; $display("FAIL rand%0d_error: got %b want %b", it, a_error, exp_err); end
         n_cmp++; if (a_cpu_reset !== exp_err) begin n_bad++; $display("FAIL rand%0d_cpu_reset: got %b want %b", it, a_cpu_reset, exp_err); end
         foreach (m_rom_a[k]) begin
            pc = 15'(k); #1;
            n_cmp++;
            if (a_instr !== (exp_err ? 16'h0000 : m_rom_a[k])) begin
               n_bad++;
               $display("FAIL rand%0d_instr[%0d]: got %h want %h", it, k, a_instr, exp_err ? 16'h0000 : m_rom_a[k]);
            end
         end
      end
   endtask

   task automatic test_reset_midload;
      logic [7:0]  s[$];
      logic [15:0] w[$];
      s = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h55};
      w = '{16'($urandom)};
      pulse_reload;
      foreach (s[i]) send(s[i], 0);
      m_rom_a[0] = 16'hABCD;
      n_cmp++; if (a_words !== 16'd1) begin n_bad++; $display("FAIL midload_words_pre: got %0d want 1", a_words); end
      pulse_reset;
      n_cmp++; if (a_words !== 16'd0) begin n_bad++; $display("FAIL midload_words_rst: got %0d want 0", a_words); end
      n_cmp++; if (a_loading !== 1'b1) begin n_bad++; $display("FAIL midload_loading: got %b want 1", a_loading); end
      n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL midload_cpu_reset_rst: got %b want 1", a_cpu_reset); end
      load_image(0, w, 8'h00, 1);
      n_cmp++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL midload_error: got %b want 0", a_error); end
      n_cmp++; if (a_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL midload_cpu_reset: got %b want 0", a_cpu_reset); end
      n_cmp++; if (a_words !== 16'd1) begin n_bad++; $display("FAIL midload_words: got %0d want 1", a_words); end
      foreach (m_rom_a[k]) begin
         pc = 15'(k); #1;
         n_cmp++; if (a_instr !== m_rom_a[k]) begin n_bad++; $display("FAIL midload_instr[%0d]: got %h want %h", k, a_instr, m_rom_a[k]); end
      end
   endtask

   task automatic test_reload_drops_byte;
      logic [15:0] w[$];
      w = '{16'h7E57};
      pc = 15'd0;
      reload = 1'b1; in_valid = 1'b1; in_data = 8'h00;
      @(posedge clock);
      #1;
      reload = 1'b0; in_valid = 1'b0;
      n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL drop_cpu_reset: got %b want 1", a_cpu_reset); end
      n_cmp++; if (a_instr !== 16'h0000) begin n_bad++; $display("FAIL drop_instr: got %h want 0000", a_instr); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL drop_in_ready: got %b want 1", a_in_ready); end
      n_cmp++; if (a_words !== 16'd0) begin n_bad++; $display("FAIL drop_words: got %0d want 0", a_words); end
      load_image(0, w, 8'h00, 0);
      n_cmp++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL drop_error: got %b want 0", a_error); end
      n_cmp++; if (a_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL drop_run: got %b want 0", a_cpu_reset); end
      #1;
      n_cmp++; if (a_instr !== 16'h7E57) begin n_bad++; $display("FAIL drop_instr_run: got %h want 7e57", a_instr); end
   endtask

   task automatic test_small_rom;
      logic [15:0] w[$];
      pulse_reset;
      send(8'h00, 0);
      send(8'h11, 0);
      n_cmp++; if (b_error !== 1'b1) begin n_bad++; $display("FAIL small_over_error: got %b want 1", b_error); end
      n_cmp++; if (b_in_ready !== 1'b0) begin n_bad++; $display("FAIL small_over_in_ready: got %b want 0", b_in_ready); end
      n_cmp++; if (b_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL small_over_cpu_reset: got %b want 1", b_cpu_reset); end
      pulse_reload;
      for (int i = 0; i < 16; i++) w.push_back(16'($urandom));
      load_image(1, w, 8'h00, 1);
      n_cmp++; if (b_error !== 1'b0) begin n_bad++; $display("FAIL small_full_error: got %b want 0", b_error); end
      n_cmp++; if (b_words !== 16'd16) begin n_bad++; $display("FAIL small_full_words: got %0d want 16", b_words); end
      n_cmp++; if (b_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL small_full_cpu_reset: got %b want 0", b_cpu_reset); end
      for (int p = 0; p < 32; p++) begin
         pc = 15'(p); #1;
         n_cmp++; if (b_instr !== m_rom_b[p % 16]) begin n_bad++; $display("FAIL small_wrap_instr[%0d]: got %h want %h", p, b_instr, m_rom_b[p % 16]); end
      end
   endtask

   initial begin
      test_reset;
      test_basic_load;
      test_gaps;
      test_bad_chk;
      test_reload_recover;
      test_zero_len;
      test_random_images;
      test_reset_midload;
      test_reload_drops_byte;
      test_small_rom;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
